pc_sequencer: RTL

Program-counter and control-flow stage for the single-cycle core. It consumes the ALU's `Out` as a branch condition and resolves absolute or relative branches through a small target lookup table. It drives the instruction-fetch address and also owns the Start/Done program handshake with the testbench. It also runs a saturating cycle counter used for performance measurement.

---
 rtl/definitions.sv | 23 ++
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/branch_lut.sv | 11 +
 rtl/pc_sequencer.sv | 84 ++++++++
 4 files changed

// File: rtl/definitions.sv
// Shared types and constants for the program-counter sequencer:
// state encoding, data/PC/LUT widths and the branch target table.
package definitions;

  localparam int W   = 8;
  localparam int PCW = 10;
  localparam int LW  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pcs_state_t;

  // Absolute targets or PCW-bit two's-complement offsets, chosen per Target index.
  localparam logic [PCW-1:0] BRANCH_LUT [2**LW] = '{
    10'h000, 10'h001, 10'h002, 10'h040, 10'h100, 10'h005, 10'h200, 10'h3FC,
    10'h004, 10'h3FE, 10'h009, 10'h3F0, 10'h055, 10'h010, 10'h020, 10'h030,
    10'h050, 10'h060, 10'h070, 10'h080, 10'h090, 10'h0A0, 10'h0B0, 10'h0C0,
    10'h0D0, 10'h0E0, 10'h0F0, 10'h3F8, 10'h3FA, 10'h3FD, 10'h008, 10'h3FF
  };

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decoder/testbench side and the sequencer.
interface pc_sequencer_if;
  import definitions::*;

  logic           Start;
  logic           Stall;
  logic           Halt;
  logic           BranchEn;
  logic           BranchRel;
  logic [LW-1:0]  Target;
  logic [W-1:0]   CondIn;
  logic [PCW-1:0] ProgCtr;
  logic           Running;
  logic           Done;
  logic           Taken;
  logic [15:0]    CycleCt;

  modport master (
    output Start, Stall, Halt, BranchEn, BranchRel, Target, CondIn,
    input  ProgCtr, Running, Done, Taken, CycleCt
  );

  modport slave (
    input  Start, Stall, Halt, BranchEn, BranchRel, Target, CondIn,
    output ProgCtr, Running, Done, Taken, CycleCt
  );

endinterface

// File: rtl/branch_lut.sv
// Combinational ROM returning the branch table entry selected by Target.
module branch_lut
  import definitions::*;
(
  input  logic [LW-1:0]  target,
  output logic [PCW-1:0] entry
);

  assign entry = BRANCH_LUT[target];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, IDLE/RUN/DONE program handshake, branch resolution and
// saturating RUN-cycle counter for the single-cycle core.
module pc_sequencer
  import definitions::*;
(
  input  logic          Clk,
  input  logic          Reset_n,
  pc_sequencer_if.slave bus
);

  pcs_state_t     state_r, state_s;
  logic [PCW-1:0] pc_r, pc_s;
  logic [15:0]    ct_r, ct_s, ct_inc_s;
  logic           taken_r, taken_s;
  logic [PCW-1:0] lut_entry_s;
  logic           cond_s;

  branch_lut u_branch_lut (
    .target (bus.Target),
    .entry  (lut_entry_s)
  );

  assign cond_s = bus.BranchEn && (bus.CondIn != {W{1'b0}});

  // Next-state, next-PC, counter and taken-pulse decode
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    ct_s     = ct_r;
    taken_s  = 1'b0;
    ct_inc_s = (ct_r == 16'hFFFF) ? ct_r : ct_r + 16'd1;
    case (state_r)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_s = RUN;
          pc_s    = {PCW{1'b0}};
          ct_s    = 16'd0;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        // Stalled cycles still count as RUN time.
        ct_s = ct_inc_s;
        if (bus.Stall) begin
          pc_s = pc_r;
        end else if (bus.Halt) begin
          state_s = DONE;
        end else if (cond_s) begin
          taken_s = 1'b1;
          // PCW-bit add wraps, which is the sign-extended relative add.
          pc_s    = bus.BranchRel ? (pc_r + lut_entry_s) : lut_entry_s;
        end else begin
          pc_s = pc_r + {{(PCW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, PC, counter and taken registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
      pc_r    <= {PCW{1'b0}};
      ct_r    <= 16'd0;
      taken_r <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      ct_r    <= ct_s;
      taken_r <= taken_s;
    end
  end

  assign bus.ProgCtr = pc_r;
  assign bus.Running = (state_r == RUN);
  assign bus.Done    = (state_r == DONE);
  assign bus.Taken   = taken_r;
  assign bus.CycleCt = ct_r;

endmodule
